serial_sign_restorer: RTL and testbench

//  Receiving end of the multiplier's serial product path. It captures the unsigned product magnitude
//  bit-serially, LSB first, and applies the result sign on the fly. The sign is restored with the

---
 rtl/serial_sign_restorer.sv | 89 ++++++++
 tb/tb_serial_sign_restorer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_sign_restorer.sv
// rtl/serial_sign_restorer.sv - bit-serial product capture with on-the-fly two's-complement sign restore
module serial_sign_restorer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             neg,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sreg;
    logic             neg_l;
    logic             seen_one;

    logic             obit;
    logic [WIDTH-1:0] sreg_next;

    // Copy up to and including the first 1, invert everything after it.
    assign obit      = (neg_l & seen_one) ? ~bit_in : bit_in;
    assign sreg_next = {obit, sreg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            sreg      <= '0;
            neg_l     <= 1'b0;
            seen_one  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            product   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        neg_l    <= neg;
                        count    <= '0;
                        sreg     <= '0;
                        seen_one <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_valid) begin
                        sreg     <= sreg_next;
                        seen_one <= seen_one | bit_in;
                        count    <= count + 1'b1;
                        if (count == LAST) begin
                            product   <= sreg_next;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sign_restorer.sv
// tb/tb_serial_sign_restorer.sv - scoreboard bench for serial_sign_restorer
module tb_serial_sign_restorer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        neg;
    logic        bit_in;
    logic        bit_valid;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [15:0] expq[$];
    logic [15:0] mon_exp;

    serial_sign_restorer #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .neg       (neg),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Inputs only change at posedge+2, so the negedge view predicts the next edge's handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                check("spurious_valid", 32'd1, 32'd0);
            end else begin
                mon_exp = expq.pop_front();
                check("product", {16'd0, product}, {16'd0, mon_exp});
            end
        end
    end

    task automatic send(input logic [15:0] mag, input logic n, input logic [15:0] stall_mask,
                        input int stall_len, output int lat);
        int st;
        expq.push_back(n ? (16'd0 - mag) : mag);
        start = 1'b1;
        neg   = n;
        tick();
        start = 1'b0;
        neg   = 1'b0;
        st    = cyc;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (stall_mask[i]) begin
                repeat (stall_len) begin
                    bit_valid = 1'b0;
                    bit_in    = $urandom_range(0, 1);
                    tick();
                end
            end
            if (i == 15) check("early_valid", {31'd0, out_valid}, 32'd0);
            bit_in    = mag[i];
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        lat = cyc - st + 1;
        check("valid_rise", {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [15:0] m;
        logic        n;
        logic [15:0] mask;
        int          len;

        rst = 1'b1; start = 1'b0; neg = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_product", {16'd0, product}, 32'd0);
        rst = 1'b0;
        tick();

        send(16'h0006, 1'b1, 16'h0, 0, lat);
        check("lat_t1", lat, 32'd17);
        tick();
        check("busy_after_hs", {31'd0, busy}, 32'd0);

        send(16'h3F01, 1'b0, 16'h0, 0, lat);
        tick();
        send(16'h4000, 1'b1, 16'h0, 0, lat);
        tick();
        send(16'h8000, 1'b1, 16'h0, 0, lat);
        tick();

        check("busy_idle_t3", {31'd0, busy}, 32'd0);
        send(16'h0000, 1'b1, 16'h0, 0, lat);
        check("busy_done_t3", {31'd0, busy}, 32'd1);
        tick();
        check("busy_end_t3", {31'd0, busy}, 32'd0);

        send(16'h00FF, 1'b1, 16'h8102, 3, lat);
        check("lat_stall", lat, 32'd26);
        tick();

        out_ready = 1'b0;
        send(16'h1234, 1'b1, 16'h0, 0, lat);
        for (int k = 0; k < 5; k++) begin
            start = (k % 2 == 0);
            tick();
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_product", {16'd0, product}, 32'h0000EDCC);
            check("hold_busy", {31'd0, busy}, 32'd1);
        end
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("hs_valid_low", {31'd0, out_valid}, 32'd0);
        check("hs_start_ignored", {31'd0, busy}, 32'd0);
        start = 1'b0;
        tick();
        check("idle_after_hs", {31'd0, busy}, 32'd0);
        check("product_kept", {16'd0, product}, 32'h0000EDCC);

        start = 1'b1;
        neg   = 1'b1;
        tick();
        start = 1'b0;
        neg   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bit_in    = 1'b1;
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_product", {16'd0, product}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bit_in    = 1'b1;
            bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        check("no_partial_valid", {31'd0, out_valid}, 32'd0);
        send(16'h0001, 1'b1, 16'h0, 0, lat);
        tick();

        for (int r = 0; r < 10; r++) begin
            m    = 16'($urandom);
            n    = 1'($urandom_range(0, 1));
            mask = 16'($urandom);
            len  = $urandom_range(0, 2);
            send(m, n, mask, len, lat);
            check("lat_rand", lat, 32'(17 + len * $countones(mask)));
            tick();
        end

        tick();
        check("queue_drained", expq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
